// File: rtl/viterbi_pkg.sv
// Shared types and constants for the K=3 Viterbi decoder control slice.
// The state enum and path-metric init values are used by viterbi_ctrl and the PM datapath.
package viterbi_pkg;

  localparam int K          = 3;
  localparam int NUM_STATES = 1 << (K - 1);
  localparam int PM_W       = 8;

  localparam logic [PM_W-1:0] PM_INIT_MAX = '1;

  typedef enum logic [2:0] {
    CLEAR = 3'd0,
    ACS   = 3'd1,
    FLUSH = 3'd2,
    TB    = 3'd3,
    DONE  = 3'd4
  } state_t;

  // Value a path metric register takes while pm_clear is high: state 0 starts as the winner.
  function automatic logic [PM_W-1:0] pm_init(input int unsigned state_idx);
    return (state_idx == 0) ? '0 : PM_INIT_MAX;
  endfunction

endpackage

// File: rtl/viterbi_addr_cnt.sv
// Up/down address counter with synchronous load, count enable and terminal-count flag.
module viterbi_addr_cnt #(
  parameter int W = 5
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_en,
  input  logic         i_up,
  input  logic [W-1:0] i_tc_val,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en) begin
      r_cnt <= i_up ? (r_cnt + W'(1)) : (r_cnt - W'(1));
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == i_tc_val);

endmodule

// File: rtl/viterbi_ctrl.sv
// Frame sequencer for the rate-1/2 K=3 Viterbi decoder: symbol intake, ACS/survivor strobes, traceback.
// Optional macro VITERBI_CTRL_NORM_EN compiles in the periodic path-metric normalization strobe.
//
//   state | meaning
//   CLEAR | load initial path metrics, clear step counter (1 cycle)
//   ACS   | accept symbol pairs; one ACS update per handshake
//   FLUSH | final ACS/survivor write of the frame (1 cycle)
//   TB    | survivor reads, address FRAME_LEN-1 down to 0
//   DONE  | last decoded bit, frame_done pulse (1 cycle)
module viterbi_ctrl
  import viterbi_pkg::*;
#(
  parameter int FRAME_LEN     = 32,
  parameter int ADDR_W        = $clog2(FRAME_LEN),
  parameter int NORM_INTERVAL = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [1:0]        i_in_pair,
  output logic [1:0]        o_bmc_pair,
  output logic              o_pm_clear,
  output logic              o_acs_en,
  output logic              o_surv_we,
  output logic [ADDR_W-1:0] o_surv_addr,
  output logic              o_tb_start,
  output logic              o_tb_rd_en,
  output logic [ADDR_W-1:0] o_tb_addr,
  output logic              o_dec_valid,
  output logic              o_dec_last,
  output logic              o_frame_done,
  output logic              o_pm_norm
);

  localparam logic [ADDR_W-1:0] LAST_STEP = ADDR_W'(FRAME_LEN - 1);

  if (FRAME_LEN < 4 || NORM_INTERVAL < 1) begin : g_param_chk
    $error("viterbi_ctrl: FRAME_LEN must be >= 4 and NORM_INTERVAL >= 1");
  end

  state_t            r_state;
  state_t            w_next;
  logic              w_hs;
  logic [ADDR_W-1:0] w_step_cnt;
  logic              w_step_tc;
  logic [ADDR_W-1:0] w_tb_cnt;
  logic              w_tb_tc;

  logic [1:0]        r_bmc_pair;
  logic              r_acs_en;
  logic [ADDR_W-1:0] r_surv_addr;
  logic              r_dec_valid;
  logic              r_dec_last;

  assign w_hs = i_in_valid & o_in_ready;

  viterbi_addr_cnt #(.W(ADDR_W)) u_step_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (r_state == CLEAR),
    .i_load_val ('0),
    .i_en       (w_hs & ~w_step_tc),
    .i_up       (1'b1),
    .i_tc_val   (LAST_STEP),
    .o_cnt      (w_step_cnt),
    .o_tc       (w_step_tc)
  );

  // Loaded during FLUSH so the first TB cycle already presents the last step address.
  viterbi_addr_cnt #(.W(ADDR_W)) u_tb_cnt (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (r_state == FLUSH),
    .i_load_val (LAST_STEP),
    .i_en       ((r_state == TB) & ~w_tb_tc),
    .i_up       (1'b0),
    .i_tc_val   ('0),
    .o_cnt      (w_tb_cnt),
    .o_tc       (w_tb_tc)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= CLEAR;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      CLEAR:   w_next = ACS;
      ACS:     if (w_hs && w_step_tc) w_next = FLUSH;
      FLUSH:   w_next = TB;
      TB:      if (w_tb_tc) w_next = DONE;
      DONE:    w_next = CLEAR;
      default: w_next = CLEAR;
    endcase
  end

  // pm_clear is masked by rst because the FSM already sits in CLEAR while reset is held.
  always_comb begin
    o_in_ready   = 1'b0;
    o_pm_clear   = 1'b0;
    o_tb_rd_en   = 1'b0;
    o_tb_start   = 1'b0;
    o_frame_done = 1'b0;
    case (r_state)
      CLEAR: o_pm_clear = ~i_rst;
      ACS:   o_in_ready = 1'b1;
      TB: begin
        o_tb_rd_en = 1'b1;
        o_tb_start = (w_tb_cnt == LAST_STEP);
      end
      DONE:  o_frame_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_bmc_pair  <= '0;
      r_acs_en    <= 1'b0;
      r_surv_addr <= '0;
      r_dec_valid <= 1'b0;
      r_dec_last  <= 1'b0;
    end else begin
      r_acs_en    <= w_hs;
      r_dec_valid <= o_tb_rd_en;
      r_dec_last  <= o_tb_rd_en & w_tb_tc;
      if (w_hs) begin
        r_bmc_pair <= i_in_pair;
      end
      if (r_state == CLEAR) begin
        r_surv_addr <= '0;
      end else if (w_hs) begin
        r_surv_addr <= w_step_cnt;
      end
    end
  end

  assign o_bmc_pair  = r_bmc_pair;
  assign o_acs_en    = r_acs_en;
  assign o_surv_we   = r_acs_en;
  assign o_surv_addr = r_surv_addr;
  assign o_tb_addr   = w_tb_cnt;
  assign o_dec_valid = r_dec_valid;
  assign o_dec_last  = r_dec_last;

`ifdef VITERBI_CTRL_NORM_EN
  localparam int NORM_W = (NORM_INTERVAL > 1) ? $clog2(NORM_INTERVAL) : 1;
  localparam logic [NORM_W-1:0] NORM_LAST = NORM_W'(NORM_INTERVAL - 1);

  logic [NORM_W-1:0] r_norm_cnt;
  logic              r_pm_norm;

  // Registered from the handshake so the pulse lines up with acs_en.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_norm_cnt <= '0;
      r_pm_norm  <= 1'b0;
    end else begin
      r_pm_norm <= w_hs && (r_norm_cnt == NORM_LAST);
      if (r_state == CLEAR) begin
        r_norm_cnt <= '0;
      end else if (w_hs) begin
        r_norm_cnt <= (r_norm_cnt == NORM_LAST) ? '0 : (r_norm_cnt + NORM_W'(1));
      end
    end
  end

  assign o_pm_norm = r_pm_norm;
`else
  assign o_pm_norm = 1'b0;
`endif

endmodule

// File: doc/viterbi_ctrl.md
# viterbi_ctrl

Frame-level sequencer for the rate-1/2, K=3 (4-state) Viterbi decoder. Accepts received symbol pairs over a valid/ready stream and registers each pair onto the branch-metric units. Strobes the ACS/path-metric update and survivor-memory writes, then runs a fixed-length traceback pass that produces decoded bits. Sits between the channel-symbol input stream and the BMC/ACS/survivor/traceback datapath.

## Interface
- FRAME_LEN, 32, symbol pairs per frame, including 2 zero tail bits; legal range is 4 or more.
- ADDR_W, $clog2(FRAME_LEN), survivor address width.
- NORM_INTERVAL, 8, accepted steps between path-metric normalization pulses. Used only with the macro.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input pair valid.
- in_ready  out  1  controller can accept a pair.
- in_pair  in  2  received symbol pair.
- bmc_pair  out  2  registered pair, driven to the BMC units.
- pm_clear  out  1  path metrics load initial values: state 0 = 0, others = max.
- acs_en  out  1  ACS update strobe for bmc_pair.
- surv_we  out  1  survivor memory write enable.
- surv_addr  out  ADDR_W  survivor write address (trellis step index).
- tb_start  out  1  traceback datapath loads start state 0.
- tb_rd_en  out  1  survivor read enable.
- tb_addr  out  ADDR_W  survivor read address.
- dec_valid  out  1  traceback datapath bit valid this cycle. Delayed tb_rd_en; memory read latency is 1.
- dec_last  out  1  with dec_valid, marks the final bit (step 0).
- frame_done  out  1  one-cycle pulse at end of frame.
- pm_norm  out  1  normalization strobe; tied 0 without the macro.

## Operation
- FSM states: CLEAR, ACS, FLUSH, TB, DONE.
- Reset: the FSM goes to CLEAR. All outputs and registers are 0, including bmc_pair, surv_addr, and tb_addr. Reset mid-frame discards the frame; no partial output is produced.
- CLEAR (1 cycle): pm_clear=1, step counter is cleared to 0, in_ready=0. Next state is ACS.
- ACS: in_ready=1.
  - On each in_valid&in_ready handshake, bmc_pair is loaded with in_pair.
  - On the next cycle, acs_en=1, surv_we=1, and surv_addr equals the step index of that pair.
  - The step counter increments by 1 per handshake.
  - The handshake at step FRAME_LEN-1 moves the FSM to FLUSH.
  - Idle cycles (in_valid=0) produce no strobes.
- FLUSH (1 cycle): in_ready=0. The final acs_en/surv_we fire here. Next state is TB.
- TB (FRAME_LEN cycles): in_ready=0.
  - tb_rd_en=1 every cycle.
  - tb_addr counts FRAME_LEN-1 down to 0.
  - tb_start=1 in the first TB cycle only.
  - After the read at address 0, the next state is DONE.
- DONE (1 cycle): carries the final dec_valid together with dec_last=1 and frame_done=1. Next state is CLEAR.
- Decoded bits appear in reverse order (last step first). Reordering is downstream.
- The decoded output has no backpressure.
- in_valid held high outside ACS is ignored; the pair is held by the source.
- No wrap of surv_addr inside a frame. The counter compares against FRAME_LEN-1, so non-power-of-two FRAME_LEN is legal.

## Timing
- Input handshake at cycle t gives acs_en/surv_we at t+1.
- Every survivor write precedes its traceback read by at least 1 cycle.
- tb_rd_en at cycle t gives dec_valid at t+1.
- With in_valid held continuously, a frame takes 2·FRAME_LEN+3 cycles: CLEAR 1, ACS FRAME_LEN, FLUSH 1, TB FRAME_LEN, DONE 1. in_ready goes low after the last handshake and rises again 2 cycles after DONE.
- acs_en, surv_we, tb_start, pm_clear, dec_last, frame_done, and pm_norm are single-cycle pulses.

## Configuration
- VITERBI_CTRL_NORM_EN defined: a normalization counter is compiled in.
  - pm_norm=1 coincident with acs_en on every NORM_INTERVAL-th update (steps NORM_INTERVAL-1, 2·NORM_INTERVAL-1, …).
  - The counter is cleared in CLEAR.
  - The ACS subtracts the minimum metric on pm_norm.
- VITERBI_CTRL_NORM_EN undefined: pm_norm is constant 0 and the counter is absent. Path metric width must then cover FRAME_LEN·2 growth.

## Structure
- viterbi_pkg holds:
  - K=3 and NUM_STATES=4;
  - the FSM state enum (CLEAR, ACS, FLUSH, TB, DONE);
  - the path-metric max/init constant used by pm_clear.
- One sub-module, viterbi_addr_cnt. It is an ADDR_W up/down counter with load, enable, and terminal-count flag. It is instantiated once for the step/surv_addr count and once for tb_addr.

## Test plan
- Reset held 3 cycles, then released:
  - all outputs are 0 during reset;
  - pm_clear=1 on the first cycle after release;
  - in_ready=1 on the next cycle.
- FRAME_LEN=8, in_valid continuous, pairs 11,10,00,01,11,00,10,01:
  - acs_en/surv_we on 8 consecutive cycles, surv_addr 0..7, bmc_pair matching each pair one cycle after its handshake;
  - tb_addr 7..0;
  - 8 dec_valid pulses, with dec_last/frame_done together at cycle 19 after CLEAR.
- FRAME_LEN=8, in_valid toggled 1,0,1,0: strobes only follow handshakes, surv_addr has no gaps, and the frame completes after 8 handshakes.
- in_valid held high through FLUSH/TB/DONE: in_ready=0, and no extra acs_en occurs. The next frame starts only after CLEAR.
- rst asserted during TB at tb_addr=3: all outputs are 0 immediately (asynchronously). After release, the FSM restarts in CLEAR with surv_addr=0.
- With VITERBI_CTRL_NORM_EN, NORM_INTERVAL=4, FRAME_LEN=8: pm_norm at steps 3 and 7 only. Without the macro, pm_norm stays 0.
